alu_arbiter: RTL

- Shares one ALU datapath between NUM_REQ requesters using round-robin arbitration.
- Accepts one operation (op, two operands, four input flags) per transaction and registers it onto the ALU inputs.
- Waits ALU_LATENCY cycles, captures the result and output flags, then returns them to the originating requester with a one-cycle valid pulse.
- Sits between the requester agents (sequencers / CPU-side ports) and the ALU interface pins.

---
 rtl/alu_arbiter_pkg.sv | 21 ++
 rtl/alu_arbiter_rr_picker.sv | 33 +++
 rtl/alu_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and widths for the ALU arbiter slice.
// Note: the optional ALU_ARB_STATS_EN feature lives in alu_arbiter.sv.
package pkg_testbench_defs;

    localparam int DATA_SIZE = 16;
    localparam int FLAG_W    = 4;

    typedef struct packed {
        logic aux_carry;
        logic neg;
        logic zero;
        logic carry;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or above the
// pointer, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    // Rotating priority search starting at ptr
    always_comb begin
        int cand;
        cand      = 0;
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!any_valid && req_valid[cand]) begin
                any_valid   = 1'b1;
                grant[cand] = 1'b1;
                winner      = IDX_W'(cand);
            end else begin
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_arbiter
    import pkg_testbench_defs::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_SIZE   = pkg_testbench_defs::DATA_SIZE,
    parameter int ALU_LATENCY = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*8-1:0]          req_op,
    input  logic [NUM_REQ*DATA_SIZE-1:0]  req_oper_a,
    input  logic [NUM_REQ*DATA_SIZE-1:0]  req_oper_b,
    input  logic [NUM_REQ*4-1:0]          req_flags,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_SIZE-1:0]          rsp_result,
    output logic [3:0]                    rsp_flags,
    output logic [7:0]                    alu_op,
    output logic [DATA_SIZE-1:0]          alu_oper_a,
    output logic [DATA_SIZE-1:0]          alu_oper_b,
    output logic [3:0]                    alu_flags,
    input  logic [DATA_SIZE-1:0]          alu_result,
    input  logic [3:0]                    alu_out_flags,
    output logic                          busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         grant_count
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(ALU_LATENCY + 1);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d, id_q, id_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             alu_op_q, alu_op_d;
    logic [DATA_SIZE-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    alu_flags_t             alu_flags_q, alu_flags_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_SIZE-1:0]   rsp_result_q, rsp_result_d;
    alu_flags_t             rsp_flags_q, rsp_flags_d;

    logic [NUM_REQ-1:0]     grant_s;
    logic [IDX_W-1:0]       winner_s;
    logic                   any_s;
    logic                   accept_s;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (grant_s),
        .winner    (winner_s),
        .any_valid (any_s)
    );

    assign req_ready = (state_q == IDLE) ? grant_s : '0;
    assign accept_s  = |(req_valid & req_ready);

    // Next-state and datapath capture
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_flags_d  = alu_flags_q;
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    alu_op_d    = req_op[8*int'(winner_s) +: 8];
                    alu_a_d     = req_oper_a[DATA_SIZE*int'(winner_s) +: DATA_SIZE];
                    alu_b_d     = req_oper_b[DATA_SIZE*int'(winner_s) +: DATA_SIZE];
                    alu_flags_d = alu_flags_t'(req_flags[4*int'(winner_s) +: 4]);
                    id_d        = winner_s;
                    cnt_d       = CNT_W'(ALU_LATENCY);
                    ptr_d       = IDX_W'((int'(winner_s) + 1) % NUM_REQ);
                    state_d     = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = WAIT;
                end
            end
            CAPTURE: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags_t'(alu_out_flags);
                rsp_valid_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << id_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            alu_op_q     <= 8'h00;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_flags_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_flags_q  <= alu_flags_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_oper_a = alu_a_q;
    assign alu_oper_b = alu_b_q;
    assign alu_flags  = alu_flags_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] grant_count_q, grant_count_d;

    // Saturating accept counter for the winning requester
    always_comb begin
        grant_count_d = grant_count_q;
        if (accept_s && (grant_count_q[16*int'(winner_s) +: 16] != 16'hFFFF)) begin
            grant_count_d[16*int'(winner_s) +: 16] = grant_count_q[16*int'(winner_s) +: 16] + 16'd1;
        end else begin
            grant_count_d = grant_count_q;
        end
    end

    // Grant counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_count_q <= '0;
        end else begin
            grant_count_q <= grant_count_d;
        end
    end

    assign grant_count = grant_count_q;
`endif

endmodule
